// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC / fetch controller.
// Holds the FSM state encoding and the default reset and trap vectors.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: +4 incrementer and jump > branch > pending > sequential mux.
// Misaligned redirect targets trap when PC_CTRL_ALIGN_CHECK_EN is defined, else get masked.
module pc_next_sel
    import pc_ctrl_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(DEF_TRAP_VEC)
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             use_pend,
    input  logic [WIDTH-1:0] pend_tgt,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] redir_tgt,
    output logic [WIDTH-1:0] next_pc,
    output logic             misaligned
);

    logic [WIDTH-1:0] raw;
    logic             is_tgt;

    assign pc_plus4  = pc + WIDTH'(WORD_BYTES);
    assign redir_tgt = jump ? jump_target : branch_target;

    // Priority mux: live redirect first, then a target deferred by a kill.
    always_comb begin
        raw    = pc_plus4;
        is_tgt = 1'b1;
        if (jump) begin
            raw = jump_target;
        end else if (branch_taken) begin
            raw = branch_target;
        end else if (use_pend) begin
            raw = pend_tgt;
        end else begin
            is_tgt = 1'b0;
        end
    end

`ifdef PC_CTRL_ALIGN_CHECK_EN
    // Misaligned target is replaced by the trap vector.
    always_comb begin
        misaligned = is_tgt && (raw[1:0] != 2'b00);
        next_pc    = misaligned ? TRAP_VEC : raw;
    end
`else
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;

    // Redirect targets are forced onto a word boundary.
    always_comb begin
        misaligned = 1'b0;
        next_pc    = raw;
        if (is_tgt) begin
            next_pc = {raw[WIDTH-1:2], 2'b00};
        end
    end
`endif

endmodule

// File: rtl/pc_fetch_controller.sv
// PC register and instruction-fetch handshake sequencer for the MIPS datapath.
// Optional misaligned-redirect trap is enabled by defining PC_CTRL_ALIGN_CHECK_EN.
module pc_fetch_controller
    import pc_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             trap
);

    state_t           state;
    state_t           state_nx;
    logic             kill;
    logic [WIDTH-1:0] pend_tgt;
    logic [WIDTH-1:0] redir_tgt;
    logic [WIDTH-1:0] next_pc;
    logic             misaligned;
    logic             redirect;
    logic             accept;
    logic             in_fetch;
    logic             in_hold;

    assign redirect  = jump | branch_taken;
    assign in_fetch  = (state == FETCH);
    assign in_hold   = (state == HOLD);
    assign accept    = in_fetch & imem_ack;
    assign imem_addr = pc;

    pc_next_sel #(
        .WIDTH    (WIDTH),
        .TRAP_VEC (TRAP_VEC)
    ) u_next (
        .pc            (pc),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .use_pend      (kill),
        .pend_tgt      (pend_tgt),
        .pc_plus4      (pc_plus4),
        .redir_tgt     (redir_tgt),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: stall only takes effect once the outstanding fetch is accepted.
    always_comb begin
        state_nx = state;
        unique case (state)
            BOOT:  state_nx = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    state_nx = stall ? HOLD : FETCH;
                end
            end
            HOLD:  state_nx = stall ? HOLD : FETCH;
            default: state_nx = BOOT;
        endcase
    end

    // Request is asserted for the whole time the FSM sits in FETCH.
    always_comb begin
        imem_req = in_fetch;
    end

    // PC, kill tracking and completed-fetch outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= RESET_VEC;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            kill        <= 1'b0;
            pend_tgt    <= '0;
        end else begin
            instr_valid <= 1'b0;
            if (accept) begin
                instr_valid <= ~(kill | redirect);
                instr_pc    <= pc;
                pc          <= next_pc;
                kill        <= 1'b0;
            end else if (in_fetch && redirect) begin
                kill     <= 1'b1;
                pend_tgt <= redir_tgt;
            end else if (in_hold && redirect) begin
                pc <= next_pc;
            end
        end
    end

`ifdef PC_CTRL_ALIGN_CHECK_EN
    logic trap_q;
    logic load_pc;

    assign load_pc = accept | (in_hold & redirect);
    assign trap    = trap_q;

    // Trap pulses on the edge that loads a misaligned target.
    always_ff @(posedge clk) begin
        if (!rst) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= load_pc & misaligned;
        end
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios plus random
// stimulus compared against a transaction-level fetch model.
module tb_pc_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_ack;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        trap;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_ipc;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_trap;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: fetch phase (0 booting, 1 requesting, 2 paused),
    // address being fetched, whether that fetch is doomed and where to go next.
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    bit          m_valid;
    bit          m_trap;
    bit          m_kill;
    logic [31:0] m_pend;

    always #5 clk = ~clk;

    pc_fetch_controller dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .instr_pc      (instr_pc),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .trap          (trap)
    );

    pc_fetch_controller #(
        .RESET_VEC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (w_valid),
        .instr_pc      (w_ipc),
        .pc            (w_pc),
        .pc_plus4      (w_pc4),
        .trap          (w_trap)
    );

    function automatic logic [31:0] fix(input logic [31:0] t, output bit tr);
`ifdef PC_CTRL_ALIGN_CHECK_EN
        tr = (t % 4) != 0;
        return tr ? 32'h80 : t;
`else
        tr = 1'b0;
        return t - (t % 4);
`endif
    endfunction

    // Advance one clock edge and update the model from the inputs held there.
    task automatic step();
        bit          tr;
        bit          redir;
        logic [31:0] t;
        @(posedge clk);
        if (!rst) begin
            m_mode  = 0;
            m_pc    = 32'h0;
            m_ipc   = 32'h0;
            m_valid = 1'b0;
            m_trap  = 1'b0;
            m_kill  = 1'b0;
            m_pend  = 32'h0;
        end else begin
            m_valid = 1'b0;
            m_trap  = 1'b0;
            redir   = jump || branch_taken;
            t       = jump ? jump_target : branch_target;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (imem_ack) begin
                    m_valid = !(m_kill || redir);
                    m_ipc   = m_pc;
                    if (redir) begin
                        m_pc   = fix(t, tr);
                        m_trap = tr;
                    end else if (m_kill) begin
                        m_pc   = fix(m_pend, tr);
                        m_trap = tr;
                    end else begin
                        m_pc = m_pc + 32'd4;
                    end
                    m_kill = 1'b0;
                    m_mode = stall ? 2 : 1;
                end else if (redir) begin
                    m_kill = 1'b1;
                    m_pend = t;
                end
            end else begin
                if (redir) begin
                    m_pc   = fix(t, tr);
                    m_trap = tr;
                end
                if (!stall) m_mode = 1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        imem_ack      = 1'b0;
    endtask

    // Reset for two edges, release, and let BOOT move to FETCH.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc: got %h want %h", pc, 32'h0);
        end
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b want 0", imem_req);
        end
        n_checks++;
        if (instr_valid !== 1'b0 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid_trap: got %b/%b want 0/0", instr_valid, trap);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL boot_req: got %b/%h want 1/%h", imem_req, imem_addr, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            step();
            n_checks++;
            if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %b/%h want 1/%h", i, instr_valid, instr_pc, exp_pc);
            end
        end
        imem_ack = 1'b0;
        step();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL b2b_after: got %b/%h want 0/%h", instr_valid, imem_addr, 32'h10);
        end
    endtask

    task automatic test_slow_memory();
        do_reset();
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL slow_wait_%0d: got %b/%h/%b want 1/%h/0", i, imem_req, imem_addr, instr_valid, 32'h8);
            end
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL slow_done: got %b/%h want 1/%h", instr_valid, instr_pc, 32'h8);
        end
        step();
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_single: got %b want 0", instr_valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) step();
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        n_checks++;
        if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_hold_addr: got %b/%h want 1/%h", imem_req, imem_addr, 32'h10);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL redir_kill: got %b/%h want 0/%h", instr_valid, imem_addr, 32'h40);
        end
        jump          = 1'b1;
        jump_target   = 32'h80;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        clear_inputs();
        imem_ack = 1'b1;
        step();
        n_checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h80) begin
            n_fail++;
            $display("FAIL redir_jump_prio: got %b/%h want 0/%h", instr_valid, imem_addr, 32'h80);
        end
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h80) begin
            n_fail++;
            $display("FAIL redir_resume: got %b/%h want 1/%h", instr_valid, instr_pc, 32'h80);
        end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ack = 1'b1;
        step();
        stall = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL stall_accept: got %b/%h want 1/%h", instr_valid, instr_pc, 32'h4);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (imem_req !== 1'b0 || pc !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %b/%h want 0/%h", i, imem_req, pc, 32'h8);
            end
            step();
        end
        stall = 1'b0;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL stall_release: got %b/%h want 1/%h", imem_req, imem_addr, 32'h8);
        end
        imem_ack = 1'b1;
        stall    = 1'b1;
        step();
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        step();
        branch_taken = 1'b0;
        n_checks++;
        if (imem_req !== 1'b0 || pc !== 32'h20) begin
            n_fail++;
            $display("FAIL stall_branch: got %b/%h want 0/%h", imem_req, pc, 32'h20);
        end
        stall = 1'b0;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL stall_branch_resume: got %b/%h want 1/%h", imem_req, imem_addr, 32'h20);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        n_checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_pc4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_first: got %b/%h/%h want 1/%h/%h", w_req, w_addr, w_pc4, 32'hFFFF_FFFC, 32'h0);
        end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (w_addr !== 32'h0 || w_valid !== 1'b1 || w_ipc !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_second: got %h/%b/%h want %h/1/%h", w_addr, w_valid, w_ipc, 32'h0, 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
        logic        exp_trap;
`ifdef PC_CTRL_ALIGN_CHECK_EN
        exp_pc   = 32'h80;
        exp_trap = 1'b1;
`else
        exp_pc   = 32'h40;
        exp_trap = 1'b0;
`endif
        do_reset();
        imem_ack      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        step();
        clear_inputs();
        n_checks++;
        if (pc !== exp_pc || trap !== exp_trap) begin
            n_fail++;
            $display("FAIL align_load: got %h/%b want %h/%b", pc, trap, exp_pc, exp_trap);
        end
        step();
        n_checks++;
        if (trap !== 1'b0) begin
            n_fail++;
            $display("FAIL align_pulse: got %b want 0", trap);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            imem_ack      = ($urandom_range(0, 1) == 1);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump          = ($urandom_range(0, 19) == 0);
            branch_target = 32'($urandom_range(0, 255));
            jump_target   = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) branch_target = branch_target & 32'hFC;
            if ($urandom_range(0, 1) == 1) jump_target = jump_target & 32'hFC;
            step();
            n_checks++;
            if (imem_req !== (m_mode == 1) || imem_addr !== m_pc || pc !== m_pc
                || pc_plus4 !== m_pc + 32'd4) begin
                n_fail++;
                $display("FAIL rand_pc_%0d: got %b/%h/%h want %b/%h", i, imem_req, pc, pc_plus4, m_mode == 1, m_pc);
            end
            n_checks++;
            if (instr_valid !== m_valid || (m_valid && instr_pc !== m_ipc) || trap !== m_trap) begin
                n_fail++;
                $display("FAIL rand_out_%0d: got %b/%h/%b want %b/%h/%b", i, instr_valid, instr_pc, trap, m_valid, m_ipc, m_trap);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #2;
        test_reset();
        test_back_to_back();
        test_slow_memory();
        test_redirect();
        test_stall();
        test_wrap();
        test_align();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
